// File: rtl/mprj_io_serial_loader.sv
// mprj_io_serial_loader
// Management-side transmitter for the two daisy-chained user-project GPIO
// configuration chains. Holds one CFG_BITS word per pad and, on start,
// shifts every word MSB-first into both chains in lockstep, then pulses
// serial_load so the pads latch their new configuration.
//
// Optional build macro: MPRJ_IO_SERIAL_LOADER_AUTOSTART_EN
//   When defined, one transfer fires by itself right after reset release
//   (once serial_resetn has been high for a cycle), so the pads receive
//   CFG_INIT without any software action.

module mprj_io_serial_loader #(
    parameter int                     NUM_IO_CHAIN = 19,
    parameter int                     CFG_BITS     = 13,
    parameter int                     CLK_DIV      = 2,
    parameter logic [CFG_BITS-1:0]    CFG_INIT     = 13'h0403,
    parameter int                     ADDR_W       = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_wdata,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_resetn,
    output logic                serial_data_1,
    output logic                serial_data_2
);

    localparam int NUM_ENT = 2 * NUM_IO_CHAIN;
    localparam int B       = NUM_IO_CHAIN * CFG_BITS;
    localparam int CNT_W   = $clog2(B + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        FINISH
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    div_d;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic [B-1:0]        sr1_q;
    logic [B-1:0]        sr2_q;
    logic [B-1:0]        snap1;
    logic [B-1:0]        snap2;
    logic                busy_q;
    logic                done_q;
    logic                sclk_q;
    logic                load_q;
    logic                data1_q;
    logic                data2_q;
    logic                srst_q;
    logic                div_last;
    logic                last_bit;
    logic                cfg_wr;
    logic                start_int;
    logic [CFG_BITS-1:0] cfg_q [NUM_ENT];

    // Configuration writes are dropped for out-of-range addresses and while
    // a transfer is running, so the snapshot being shifted never changes.
    assign cfg_wr = cfg_we && !busy_q && (cfg_addr < ADDR_W'(NUM_ENT));

    // Divider and bit counter helpers.
    assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d     = div_q + DIV_W'(1);
    assign bit_cnt_d = bit_cnt_q + CNT_W'(1);
    assign last_bit  = (bit_cnt_d == CNT_W'(B));

`ifdef MPRJ_IO_SERIAL_LOADER_AUTOSTART_EN
    logic auto_q;

    // One-shot internal start, armed by reset, fired the cycle after the
    // chains come out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            auto_q <= 1'b1;
        end else if (auto_q && srst_q) begin
            auto_q <= 1'b0;
        end
    end

    assign start_int = start | (auto_q & srst_q);
`else
    assign start_int = start;
`endif

    // Snapshot layout: slot 0 (shifted first) sits in the top bits.
    // Chain 1 runs entry N-1 down to 0; chain 2 runs entry N up to 2N-1.
    for (genvar j = 0; j < NUM_IO_CHAIN; j++) begin : g_snap
        assign snap1[(NUM_IO_CHAIN-j)*CFG_BITS-1 -: CFG_BITS] = cfg_q[NUM_IO_CHAIN-1-j];
        assign snap2[(NUM_IO_CHAIN-j)*CFG_BITS-1 -: CFG_BITS] = cfg_q[NUM_IO_CHAIN+j];
    end

    // Configuration entry storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                cfg_q[i] <= CFG_INIT;
            end
        end else if (cfg_wr) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (cfg_addr == ADDR_W'(i)) begin
                    cfg_q[i] <= cfg_wdata;
                end
            end
        end
    end

    // Chain reset is held low during reset and released on the first edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            srst_q <= 1'b0;
        end else begin
            srst_q <= 1'b1;
        end
    end

    // Transfer FSM; every serial output is a register set on the transition
    // into the state that owns it, so outputs are glitch-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sr1_q     <= '0;
            sr2_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            load_q    <= 1'b0;
            data1_q   <= 1'b0;
            data2_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_int) begin
                        state_q   <= SHIFT_LO;
                        busy_q    <= 1'b1;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                        sr1_q     <= snap1;
                        sr2_q     <= snap2;
                        data1_q   <= snap1[B-1];
                        data2_q   <= snap2[B-1];
                        sclk_q    <= 1'b0;
                    end
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end else begin
                        div_q <= div_d;
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        div_q     <= '0;
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_d;
                        if (last_bit) begin
                            // All bits out: park data low and latch the chains.
                            state_q <= LOAD;
                            data1_q <= 1'b0;
                            data2_q <= 1'b0;
                            load_q  <= 1'b1;
                        end else begin
                            // Data only moves together with the falling clock.
                            state_q <= SHIFT_LO;
                            sr1_q   <= {sr1_q[B-2:0], 1'b0};
                            sr2_q   <= {sr2_q[B-2:0], 1'b0};
                            data1_q <= sr1_q[B-2];
                            data2_q <= sr2_q[B-2];
                        end
                    end else begin
                        div_q <= div_d;
                    end
                end
                LOAD: begin
                    if (div_last) begin
                        div_q   <= '0;
                        load_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        div_q <= div_d;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    load_q  <= 1'b0;
                    data1_q <= 1'b0;
                    data2_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign serial_clock  = sclk_q;
    assign serial_load   = load_q;
    assign serial_resetn = srst_q;
    assign serial_data_1 = data1_q;
    assign serial_data_2 = data2_q;

endmodule

// File: doc/mprj_io_serial_loader.md
Name: mprj_io_serial_loader

Overview:
- Management-side transmitter for the user-project GPIO configuration chains.
- Holds one configuration word per IO pad and, on request, shifts all words serially into the two daisy-chained pad control chains. The chains are clocked by serial_clock and latched by serial_load.
- Sits in housekeeping, on the management end of the pad interface, driving the chains that the pad-side control blocks receive.

Parameters:
- NUM_IO_CHAIN, 19, IO pads per chain. Chain 1 holds entries 0..N-1; chain 2 holds entries N..2N-1.
- CFG_BITS, 13, configuration bits per pad.
- CLK_DIV, 2, serial_clock half-period in clk cycles (>=1).
- CFG_INIT, 13'h0403, reset value of every config entry.
- ADDR_W, 6, config address width (>= clog2(2*NUM_IO_CHAIN)).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- cfg_we  input  1  config write strobe.
- cfg_addr  input  ADDR_W  entry index.
- cfg_wdata  input  CFG_BITS  entry write data.
- start  input  1  single-cycle request to transfer all entries.
- busy  output  1  transfer in progress.
- done  output  1  single-cycle pulse at transfer end.
- serial_clock  output  1  chain shift clock.
- serial_load  output  1  chain latch strobe.
- serial_resetn  output  1  chain reset, active low.
- serial_data_1  output  1  chain 1 data.
- serial_data_2  output  1  chain 2 data.

Behaviour:
- Reset (async, resetn=0):
  - All entries = CFG_INIT.
  - busy, done, serial_clock, serial_load, serial_data_1/2 = 0.
  - serial_resetn = 0.
  - FSM = IDLE.
  - serial_resetn rises on the first clk edge after resetn deasserts.
- Writes: on the clk edge with cfg_we=1, entry[cfg_addr] <= cfg_wdata.
  - Ignored when cfg_addr >= 2*NUM_IO_CHAIN.
  - Ignored while busy=1.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, FINISH.
- IDLE:
  - start=1 moves to SHIFT_LO with busy=1 from the next cycle, and snapshots all entries into the shift registers.
  - start while busy is ignored.
- Shift order:
  - Chain 1 sends entry N-1 first, down to entry 0.
  - Chain 2 sends entry N first, up to entry 2N-1.
  - Each word goes MSB first.
  - Both chains shift in lockstep: total bits B = NUM_IO_CHAIN*CFG_BITS.
- SHIFT_LO: serial_clock=0 and data outputs present the current bit; lasts CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI: serial_clock=1 and data is held stable; lasts CLK_DIV cycles.
  - Bit counter increments.
  - If counter < B, return to SHIFT_LO with the next bit; else go to LOAD.
- Data changes only while serial_clock=0; it is stable at every rising edge.
- LOAD: serial_clock=0, serial_data_1/2=0, serial_load=1 for CLK_DIV cycles; then FINISH.
- FINISH: one cycle with done=1 and busy=0 in the same cycle; then IDLE.
- Latency from start to done = 1 + B*2*CLK_DIV + CLK_DIV + 1 cycles.
- Counters: bit counter width = clog2(B+1); CLK_DIV divider width = clog2(CLK_DIV+1). No wrap-around inside a transfer.
- Simultaneous cfg_we and start in IDLE: the write lands, and the snapshot taken that edge uses the pre-write value.
- Reset mid-transfer: aborts immediately; no serial_load or done is emitted; entries return to CFG_INIT.

Optional Feature:
- Macro: MPRJ_IO_SERIAL_LOADER_AUTOSTART_EN.
- Defined: after reset release, an internal start fires automatically once serial_resetn has been high for 1 cycle. Pads therefore receive CFG_INIT with no software action; the external start port still works afterwards.
- Undefined: transfers occur only on external start.

Test Plan:
- Reset then idle with N=19, CFG_BITS=13, CLK_DIV=2: all outputs 0, serial_resetn 0 -> serial_resetn 1 one cycle after release, no serial_clock toggles.
- Write entry0=13'h1FFF, entry18=13'h0001, entry19=13'h1555, rest 0; pulse start:
  - 247 rising serial_clock edges, 4 clk cycles per bit.
  - serial_data_1 first 13 bits = 0000000000001, last 13 = all ones.
  - serial_data_2 first 13 = 1010101010101.
  - serial_load high for 2 cycles, done at cycle 992 after start.
- start asserted again while busy, plus cfg_we to entry 5 mid-shift -> no restart, entry 5 unchanged on the next transfer.
- cfg_addr=38 write -> no entry modified (readback via a subsequent transfer shows CFG_INIT pattern unchanged).
- resetn pulsed low at bit 100 -> all outputs 0 asynchronously, no serial_load, no done; a new start afterwards sends CFG_INIT for all entries.
- With MPRJ_IO_SERIAL_LOADER_AUTOSTART_EN: release reset -> busy rises without start, 247 bits of repeating 13'h0403 per chain, done once.
